// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared types for the two-requester ALU arbiter.
//   opcode_t : 2-bit ALU operation code carried on each request port
//   state_t  : sequencer states (IDLE -> EXEC -> RESP -> IDLE)
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational WIDTH-bit ADD/SUB/AND/OR unit.
// Ports:
//   op_i     : operation (opcode_t)
//   a_i, b_i : operands
//   result_o : result modulo 2^WIDTH
//   carry_o  : ADD carry-out, SUB no-borrow (1 when a >= b), 0 for logic ops
//   zero_o   : result == 0
// ----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  opcode_t            op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   result_o,
    output logic               carry_o,
    output logic               zero_o
);

    // One extra bit so the carry / no-borrow falls out of the top position.
    logic [WIDTH:0] sum_s;

    // Operation select; subtraction is a + ~b + 1 so its carry means no borrow.
    always_comb begin
        sum_s = {(WIDTH+1){1'b0}};
        case (op_i)
            OP_ADD:  sum_s = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  sum_s = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
            OP_AND:  sum_s = {1'b0, a_i & b_i};
            OP_OR:   sum_s = {1'b0, a_i | b_i};
            default: sum_s = {(WIDTH+1){1'b0}};
        endcase
    end

    assign result_o = sum_s[WIDTH-1:0];
    assign carry_o  = sum_s[WIDTH];
    assign zero_o   = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});

endmodule

// File: rtl/alu_arbiter_seq.sv
// ----------------------------------------------------------------------------
// alu_arbiter_seq
// Shares one ALU between two requesters. A round-robin arbiter grants one
// request in IDLE, operands are latched, the result is registered in EXEC and
// presented in RESP on the winning requester's resp_valid bit until taken.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   req_valid/req_ready   : per-requester request handshake (ready one-hot)
//   req_op/req_a/req_b    : per-requester opcode and operands, slice i
//   resp_valid/resp_ready : per-requester response handshake
//   resp_data/carry/zero  : shared registered result and flags
//   busy                  : sequencer is not in IDLE
// ----------------------------------------------------------------------------
module alu_arbiter_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [WIDTH-1:0]        resp_data,
    output logic                    resp_carry,
    output logic                    resp_zero,
    output logic                    busy
);

    state_t             state_q, state_d;
    logic               idx_q, idx_d;
    logic               rr_last_q, rr_last_d;
    opcode_t            op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               carry_q, carry_d, zero_q, zero_d;

    logic [NREQ-1:0]    grant_s;
    logic               grant_idx_s;
    logic [WIDTH-1:0]   core_result_s;
    logic               core_carry_s, core_zero_s;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (core_result_s),
        .carry_o  (core_carry_s),
        .zero_o   (core_zero_s)
    );

    // Round-robin grant: a lone requester wins; on contention the requester
    // that did not win last time wins. Held low during reset.
    always_comb begin
        grant_s = 2'b00;
        if ((state_q == IDLE) && rst_n) begin
            if (req_valid == 2'b11) begin
                grant_s = rr_last_q ? 2'b01 : 2'b10;
            end else begin
                grant_s = req_valid;
            end
        end else begin
            grant_s = 2'b00;
        end
    end

    assign grant_idx_s = grant_s[1];

    // Next-state and datapath register loads for the sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rr_last_d = rr_last_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        case (state_q)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    state_d   = EXEC;
                    idx_d     = grant_idx_s;
                    rr_last_d = grant_idx_s;
                    op_d      = opcode_t'(grant_idx_s ? req_op[3:2] : req_op[1:0]);
                    a_d       = grant_idx_s ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                    b_d       = grant_idx_s ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                data_d  = core_result_s;
                carry_d = core_carry_s;
                zero_d  = core_zero_s;
                state_d = RESP;
            end
            RESP: begin
                // Only the owning requester's resp_ready can retire the result.
                if (resp_ready[idx_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and datapath registers; rr_last resets to 1 so requester 0
    // wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 1'b0;
            rr_last_q <= 1'b1;
            op_q      <= OP_ADD;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            data_q    <= {WIDTH{1'b0}};
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rr_last_q <= rr_last_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            data_q    <= data_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
        end
    end

    // Response valid is decoded from registered state only.
    always_comb begin
        resp_valid = 2'b00;
        if (state_q == RESP) begin
            resp_valid[idx_q] = 1'b1;
        end else begin
            resp_valid = 2'b00;
        end
    end

    assign req_ready  = grant_s;
    assign resp_data  = data_q;
    assign resp_carry = carry_q;
    assign resp_zero  = zero_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter_seq
// Directed scenarios with literal expectations, then randomized traffic, all
// checked every cycle against a transaction-level model of the shared ALU.
// ----------------------------------------------------------------------------
module tb_alu_arbiter_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [15:0] req_a = 16'h0000;
    logic [15:0] req_b = 16'h0000;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b00;
    logic [7:0]  resp_data;
    logic        resp_carry, resp_zero, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter_seq #(.WIDTH(8), .NREQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
        .resp_zero  (resp_zero),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting, got nothing expected event at %0t", name, $time);
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic void model_alu(input int op, input int a, input int b,
                                      output int r, output int c, output int z);
        int s;
        case (op)
            0: begin s = a + b; r = s % 256; c = (s > 255) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
            2: begin r = a & b; c = 0; end
            3: begin r = a | b; c = 0; end
            default: begin r = 0; c = 0; end
        endcase
        z = (r == 0) ? 1 : 0;
    endfunction

    // Transaction-level model: m_stage counts where the one in-flight job is
    // (0 none, 1 accepted and computing, 2 result offered to requester m_idx).
    int m_stage = 0, m_idx = 0, m_rr = 1;
    int m_data = 0, m_c = 0, m_z = 0;
    int p_data, p_c, p_z;
    logic [1:0] m_grant, m_rv;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_data", resp_data, 0);
            chk("rst_carry", resp_carry, 0);
            chk("rst_zero", resp_zero, 0);
            m_stage = 0; m_rr = 1; m_data = 0; m_c = 0; m_z = 0;
        end else begin
            m_grant = 2'b00;
            if (m_stage == 0) begin
                if (req_valid == 2'b11) m_grant = (m_rr == 1) ? 2'b01 : 2'b10;
                else m_grant = req_valid;
            end
            m_rv = (m_stage == 2) ? (2'b01 << m_idx) : 2'b00;
            chk("m_req_ready", req_ready, m_grant);
            chk("m_busy", busy, (m_stage != 0) ? 1 : 0);
            chk("m_resp_valid", resp_valid, m_rv);
            chk("m_resp_data", resp_data, m_data);
            chk("m_resp_carry", resp_carry, m_c);
            chk("m_resp_zero", resp_zero, m_z);
            // advance across the coming rising edge
            if (m_stage == 0 && m_grant != 2'b00) begin
                m_idx = m_grant[1] ? 1 : 0;
                m_rr  = m_idx;
                model_alu(int'(req_op[2*m_idx +: 2]), int'(req_a[8*m_idx +: 8]),
                          int'(req_b[8*m_idx +: 8]), p_data, p_c, p_z);
                m_stage = 1;
            end else if (m_stage == 1) begin
                m_data = p_data; m_c = p_c; m_z = p_z;
                m_stage = 2;
            end else if (m_stage == 2 && resp_ready[m_idx]) begin
                m_stage = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input int op, input int a, input int b);
        req_valid[i]       = v;
        req_op[2*i +: 2]   = op[1:0];
        req_a[8*i +: 8]    = a[7:0];
        req_b[8*i +: 8]    = b[7:0];
    endtask

    // Present a request and hold it until accepted; returns just after the
    // accepting edge with valid dropped.
    task automatic do_req(input int i, input int op, input int a, input int b);
        int k = 0;
        set_req(i, 1'b1, op, a, b);
        @(negedge clk);
        while (!req_ready[i] && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[i]) timeout("do_req_ready");
        tick();
        req_valid[i] = 1'b0;
    endtask

    // Wait for a response, check it with literal values, then consume it.
    task automatic get_resp(input int i, input int d, input int c, input int z);
        int k = 0;
        logic [1:0] e;
        e = 2'b01 << i;
        @(negedge clk);
        while (resp_valid == 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (resp_valid == 2'b00) timeout("get_resp_valid");
        chk("resp_port", resp_valid, e);
        chk("resp_data", resp_data, d);
        chk("resp_carry", resp_carry, c);
        chk("resp_zero", resp_zero, z);
        tick();
        resp_ready[i] = 1'b1;
        tick();
        resp_ready[i] = 1'b0;
    endtask

    logic [1:0] hs_s;
    logic [1:0] exp_g;
    int         ng, cyc;

    initial begin
        // reset
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single ADD with exact latency
        set_req(0, 1'b1, 0, 'h7F, 'h01);
        @(negedge clk);
        chk("t1_ready_same_cycle", req_ready, 2'b01);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_exec_no_valid", resp_valid, 2'b00);
        chk("t1_exec_busy", busy, 1);
        tick();
        @(negedge clk);
        chk("t1_resp_valid", resp_valid, 2'b01);
        chk("t1_data", resp_data, 'h80);
        chk("t1_carry", resp_carry, 0);
        chk("t1_zero", resp_zero, 0);
        tick();
        resp_ready[0] = 1'b1;
        tick();
        resp_ready[0] = 1'b0;

        // wrap and flags on port 1
        do_req(1, 0, 'hFF, 'h01);
        get_resp(1, 'h00, 1, 1);
        do_req(1, 1, 'h05, 'h07);
        get_resp(1, 'hFE, 0, 0);

        // contention: alternating grants 0,1,0,1
        set_req(0, 1'b1, 2, 'hF0, 'h3C);
        set_req(1, 1'b1, 3, 'hF0, 'h0F);
        resp_ready = 2'b11;
        ng = 0; cyc = 0;
        while (ng < 4 && cyc < 40) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                exp_g = (ng % 2 == 0) ? 2'b01 : 2'b10;
                chk("t3_grant_order", req_ready, exp_g);
                ng++;
            end
            if (resp_valid == 2'b01) chk("t3_resp0", resp_data, 'h30);
            if (resp_valid == 2'b10) chk("t3_resp1", resp_data, 'hFF);
            cyc++;
            tick();
        end
        if (ng < 4) timeout("t3_grants");
        req_valid = 2'b00;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid == 2'b01) chk("t3_resp0", resp_data, 'h30);
            if (resp_valid == 2'b10) chk("t3_resp1", resp_data, 'hFF);
            tick();
        end
        resp_ready = 2'b00;

        // response backpressure with the other port waiting
        do_req(0, 0, 'h12, 'h34);
        set_req(1, 1'b1, 3, 'h0F, 'hF0);
        cyc = 0;
        @(negedge clk);
        while (resp_valid == 2'b00 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (resp_valid == 2'b00) timeout("t4_resp");
        for (int j = 0; j < 5; j++) begin
            chk("t4_hold_valid", resp_valid, 2'b01);
            chk("t4_hold_data", resp_data, 'h46);
            chk("t4_no_ready", req_ready, 2'b00);
            chk("t4_busy", busy, 1);
            tick();
            @(negedge clk);
        end
        tick();
        resp_ready[0] = 1'b1;
        @(negedge clk);
        tick();
        resp_ready[0] = 1'b0;
        @(negedge clk);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_valid", resp_valid, 2'b00);
        chk("t4_idle_grant1", req_ready, 2'b10);
        tick();
        req_valid[1] = 1'b0;
        get_resp(1, 'hFF, 0, 0);

        // async reset while in EXEC
        do_req(0, 0, 'h22, 'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_resp_valid", resp_valid, 2'b00);
        chk("t5_req_ready", req_ready, 2'b00);
        chk("t5_data", resp_data, 0);
        chk("t5_carry", resp_carry, 0);
        chk("t5_zero", resp_zero, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_discarded", resp_data, 0);
        tick();
        do_req(0, 1, 'h10, 'h10);
        get_resp(0, 'h00, 1, 1);

        // withdrawn request while busy
        do_req(0, 0, 'h01, 'h02);
        set_req(1, 1'b1, 0, 'h05, 'h06);
        tick();
        req_valid[1] = 1'b0;
        get_resp(0, 'h03, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_resp1", resp_valid, 2'b00);
            tick();
        end
        set_req(0, 1'b1, 0, 'h01, 'h01);
        set_req(1, 1'b1, 0, 'h05, 'h06);
        @(negedge clk);
        chk("t6_rr_order", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        get_resp(1, 'h0B, 0, 0);

        // randomized traffic, checked by the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            hs_s = req_valid & req_ready;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && !hs_s[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) != 0) begin
                    set_req(i, 1'b1, $urandom_range(0, 3), $urandom_range(0, 255),
                            $urandom_range(0, 255));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = 2'($urandom_range(0, 3));
        end
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
